// File: rtl/wb_retire_queue.sv
// In-order writeback stage with a small retire queue.
// Non-load results are muxed on entry and retire as soon as they reach the head.
// Loads wait at the head for the memory response. The response word is captured
// into a retire register, then aligned and extended into the register-file write
// port on the following edge.
module wb_retire_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_sel,
  input  logic                     in_jump,
  input  logic [XLEN-1:0]          in_alu,
  input  logic [XLEN-1:0]          in_pc_incr,
  input  logic [XLEN-1:0]          in_pc_offset,
  input  logic [XLEN-1:0]          in_imm,
  input  logic [AW-1:0]            in_rd,
  input  logic                     in_regwrite,
  input  logic [2:0]               in_funct3,
  input  logic [1:0]               in_byte_off,
  input  logic                     mem_rsp_valid,
  input  logic [XLEN-1:0]          mem_rsp_data,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_waddr,
  output logic [XLEN-1:0]          rf_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (XLEN != 32 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("wb_retire_queue: XLEN must be 32 and DEPTH a power of two >= 2");
  end

  // queue storage; only pointers and count need reset
  logic [XLEN-1:0] r_data  [DEPTH];
  logic            r_load  [DEPTH];
  logic [AW-1:0]   r_rd    [DEPTH];
  logic            r_rw    [DEPTH];
  logic [2:0]      r_f3    [DEPTH];
  logic [1:0]      r_off   [DEPTH];

  logic [PW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count;

  // retire register between queue pop and register-file port
  logic            r_s1_vld, r_s1_we, r_s1_load;
  logic [AW-1:0]   r_s1_rd;
  logic [XLEN-1:0] r_s1_data;
  logic [2:0]      r_s1_f3;
  logic [1:0]      r_s1_off;

  logic            w_empty, w_enq, w_head_load, w_retire, w_rsp_err;
  logic [XLEN-1:0] w_res, w_ext;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic            w_bad_f3;

  assign w_empty     = (r_count == '0);
  assign in_ready    = (r_count < CW'(DEPTH));
  assign w_enq       = in_valid && in_ready;
  assign w_head_load = !w_empty && r_load[r_rptr];
  assign w_retire    = !w_empty && (!r_load[r_rptr] || mem_rsp_valid);
  assign w_rsp_err   = mem_rsp_valid && !w_head_load;
  assign count       = r_count;

  // non-load result select at enqueue
  always_comb begin
    w_res = '0;
    case (in_sel)
      2'd0:    w_res = in_alu;
      2'd2:    w_res = in_jump ? in_pc_incr : in_pc_offset;
      2'd3:    w_res = in_imm;
      default: w_res = '0;
    endcase
  end

  // load alignment and sign/zero extension on the retired word
  always_comb begin
    w_byte   = r_s1_data[8*r_s1_off +: 8];
    w_half   = r_s1_off[1] ? r_s1_data[31:16] : r_s1_data[15:0];
    w_bad_f3 = 1'b0;
    w_ext    = r_s1_data;
    if (r_s1_load) begin
      case (r_s1_f3)
        3'b000:  w_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
        3'b100:  w_ext = {{(XLEN-8){1'b0}}, w_byte};
        3'b001:  w_ext = {{(XLEN-16){w_half[15]}}, w_half};
        3'b101:  w_ext = {{(XLEN-16){1'b0}}, w_half};
        3'b010:  w_ext = r_s1_data;
        default: begin
          w_ext    = r_s1_data;
          w_bad_f3 = 1'b1;
        end
      endcase
    end
  end

  // entry write on enqueue
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_data[r_wptr] <= w_res;
      r_load[r_wptr] <= (in_sel == 2'd1);
      r_rd[r_wptr]   <= in_rd;
      r_rw[r_wptr]   <= in_regwrite;
      r_f3[r_wptr]   <= in_funct3;
      r_off[r_wptr]  <= in_byte_off;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq)    r_wptr <= r_wptr + 1'b1;
      if (w_retire) r_rptr <= r_rptr + 1'b1;
      if (w_enq && !w_retire)      r_count <= r_count + 1'b1;
      else if (!w_enq && w_retire) r_count <= r_count - 1'b1;
    end
  end

  // capture the retiring head; loads take the response word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_we   <= 1'b0;
      r_s1_load <= 1'b0;
      r_s1_rd   <= '0;
      r_s1_data <= '0;
      r_s1_f3   <= '0;
      r_s1_off  <= '0;
    end else begin
      r_s1_vld <= w_retire;
      if (w_retire) begin
        r_s1_we   <= r_rw[r_rptr] && (r_rd[r_rptr] != '0);
        r_s1_load <= r_load[r_rptr];
        r_s1_rd   <= r_rd[r_rptr];
        r_s1_data <= r_load[r_rptr] ? mem_rsp_data : r_data[r_rptr];
        r_s1_f3   <= r_f3[r_rptr];
        r_s1_off  <= r_off[r_rptr];
      end
    end
  end

  // register-file write port; address/data hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= r_s1_vld && r_s1_we;
      if (r_s1_vld) begin
        rf_waddr <= r_s1_rd;
        rf_wdata <= w_ext;
      end
    end
  end

  // sticky error: stray responses and unsupported load encodings
  always_ff @(posedge clk or posedge rst) begin
    if (rst) proto_err <= 1'b0;
    else if (w_rsp_err || (r_s1_vld && w_bad_f3)) proto_err <= 1'b1;
  end

endmodule

// File: tb/tb_wb_retire_queue.sv
// Scoreboard bench for wb_retire_queue: expected writes are queued as
// instructions are driven and compared in order as rf_we pulses.
module tb_wb_retire_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_jump, in_regwrite;
  logic [1:0]  in_sel, in_byte_off;
  logic [31:0] in_alu, in_pc_incr, in_pc_offset, in_imm;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  count;
  logic        proto_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [36:0] sb[$];

  always #5 clk = ~clk;

  wb_retire_queue #(.XLEN(32), .DEPTH(4), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_jump(in_jump),
    .in_alu(in_alu), .in_pc_incr(in_pc_incr), .in_pc_offset(in_pc_offset), .in_imm(in_imm),
    .in_rd(in_rd), .in_regwrite(in_regwrite), .in_funct3(in_funct3), .in_byte_off(in_byte_off),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .count(count), .proto_err(proto_err)
  );

  // in-order write checker
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      logic [36:0] exp;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", rf_waddr, rf_wdata);
      end else begin
        exp = sb.pop_front();
        if ({rf_waddr, rf_wdata} !== exp)
          $display("FAIL write_order: got rd=%0d data=%h, required rd=%0d data=%h",
                   rf_waddr, rf_wdata, exp[36:32], exp[31:0]);
        else n_pass++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  // load the input bus; unselected fields get junk so the mux is exercised
  task automatic set_op(input logic [1:0] sel, input logic jmp, input logic [31:0] val,
                        input logic [4:0] rd, input logic rw, input logic [2:0] f3,
                        input logic [1:0] off);
    in_sel = sel; in_jump = jmp; in_rd = rd; in_regwrite = rw;
    in_funct3 = f3; in_byte_off = off;
    in_alu = $urandom; in_pc_incr = $urandom; in_pc_offset = $urandom; in_imm = $urandom;
    case (sel)
      2'd0: in_alu = val;
      2'd2: if (jmp) in_pc_incr = val; else in_pc_offset = val;
      2'd3: in_imm = val;
      default: ;
    endcase
    in_valid = 1'b1;
  endtask

  task automatic enq(input logic [1:0] sel, input logic jmp, input logic [31:0] val,
                     input logic [4:0] rd, input logic rw, input logic [2:0] f3,
                     input logic [1:0] off);
    set_op(sel, jmp, val, rd, rw, f3, off);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] w);
    mem_rsp_valid = 1'b1; mem_rsp_data = w;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
  endtask

  task automatic apply_reset;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset;
    n_checks++; if ({count, rf_we, rf_waddr, rf_wdata, proto_err} !== '0)
      $display("FAIL reset_state: got cnt=%0d we=%b a=%0d d=%h err=%b, required all 0",
               count, rf_we, rf_waddr, rf_wdata, proto_err); else n_pass++;
    n_checks++; if (in_ready !== 1'b1)
      $display("FAIL reset_ready: got %b, required 1", in_ready); else n_pass++;
  endtask

  task automatic test_reset_midload;
    enq(2'd1, 0, 0, 5'd3, 1, 3'b010, 2'd0);
    enq(2'd1, 0, 0, 5'd4, 1, 3'b010, 2'd0);
    n_checks++; if (count !== 3'd2)
      $display("FAIL midload_count: got %0d, required 2", count); else n_pass++;
    #3 rst = 1'b1; #1;
    n_checks++; if ({count, rf_we, proto_err} !== '0)
      $display("FAIL midload_reset: got cnt=%0d we=%b err=%b, required 0 0 0",
               count, rf_we, proto_err); else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (count !== 3'd0)
      $display("FAIL midload_empty: got %0d, required 0", count); else n_pass++;
    respond(32'h1111_2222);
    n_checks++; if (proto_err !== 1'b1)
      $display("FAIL late_rsp_err: got %b, required 1", proto_err); else n_pass++;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (proto_err !== 1'b1)
      $display("FAIL err_sticky: got %b, required 1", proto_err); else n_pass++;
    apply_reset();
    n_checks++; if (proto_err !== 1'b0)
      $display("FAIL err_clear: got %b, required 0", proto_err); else n_pass++;
  endtask

  task automatic test_latency;
    sb.push_back({5'd5, 32'h1234});
    enq(2'd0, 0, 32'h1234, 5'd5, 1, 3'b0, 2'd0);   // accepted at edge k
    n_checks++; if (rf_we !== 1'b0)
      $display("FAIL lat_k: got we=%b, required 0", rf_we); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (rf_we !== 1'b0)
      $display("FAIL lat_k1: got we=%b, required 0", rf_we); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h1234})
      $display("FAIL lat_k2: got we=%b a=%0d d=%h, required 1 5 00001234",
               rf_we, rf_waddr, rf_wdata); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd5, 32'h1234})
      $display("FAIL lat_hold: got we=%b a=%0d d=%h, required 0 5 00001234",
               rf_we, rf_waddr, rf_wdata); else n_pass++;
  endtask

  task automatic test_load_ext;
    logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  offs [5] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd0};
    logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                              32'h0000_80FF, 32'h80FF_0000};
    for (int i = 0; i < 5; i++) begin
      sb.push_back({5'(10 + i), exps[i]});
      enq(2'd1, 0, 0, 5'(10 + i), 1, f3s[i], offs[i]);
      repeat (2) @(posedge clk);   // load waits at head
      #1 respond(32'h80FF_0000);
    end
    // low byte/half positions with the opposite sign
    sb.push_back({5'd20, 32'h0000_007F});
    enq(2'd1, 0, 0, 5'd20, 1, 3'b000, 2'd1);
    respond(32'h1234_7F00);
    sb.push_back({5'd21, 32'h0000_7F00});
    enq(2'd1, 0, 0, 5'd21, 1, 3'b001, 2'd0);
    respond(32'h1234_7F00);
    repeat (4) @(posedge clk); #1;
    n_checks++; if (proto_err !== 1'b0)
      $display("FAIL load_no_err: got %b, required 0", proto_err); else n_pass++;
    // unsupported encoding writes the raw word and flags an error
    sb.push_back({5'd12, 32'h1234_5678});
    enq(2'd1, 0, 0, 5'd12, 1, 3'b011, 2'd1);
    respond(32'h1234_5678);
    repeat (3) @(posedge clk); #1;
    n_checks++; if (proto_err !== 1'b1)
      $display("FAIL bad_f3_err: got %b, required 1", proto_err); else n_pass++;
    n_checks++; if (sb.size() !== 0)
      $display("FAIL load_drain: got %0d pending, required 0", sb.size()); else n_pass++;
    apply_reset();
  endtask

  task automatic test_backpressure;
    sb.push_back({5'd7, 32'hCAFE_F00D});
    sb.push_back({5'd8, 32'h11});
    sb.push_back({5'd9, 32'h22});
    sb.push_back({5'd10, 32'h33});
    enq(2'd1, 0, 0, 5'd7, 1, 3'b010, 2'd0);
    enq(2'd0, 0, 32'h11, 5'd8, 1, 3'b0, 2'd0);
    enq(2'd0, 0, 32'h22, 5'd9, 1, 3'b0, 2'd0);
    enq(2'd0, 0, 32'h33, 5'd10, 1, 3'b0, 2'd0);
    n_checks++; if ({count, in_ready} !== {3'd4, 1'b0})
      $display("FAIL full: got cnt=%0d rdy=%b, required 4 0", count, in_ready); else n_pass++;
    set_op(2'd0, 0, 32'hBAD0, 5'd11, 1, 3'b0, 2'd0);   // must be refused
    repeat (10) @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd4)
      $display("FAIL full_hold: got %0d, required 4", count); else n_pass++;
    respond(32'hCAFE_F00D);
    repeat (8) @(posedge clk); #1;
    n_checks++; if ({count, sb.size() == 0} !== {3'd0, 1'b1})
      $display("FAIL bp_drain: got cnt=%0d pending=%0d, required 0 0", count, sb.size());
    else n_pass++;
  endtask

  task automatic test_link_rd0;
    sb.push_back({5'd1, 32'h104});
    sb.push_back({5'd3, 32'h2000});
    sb.push_back({5'd4, 32'hABCD_E000});
    enq(2'd2, 1, 32'h104, 5'd1, 1, 3'b0, 2'd0);         // edge k
    enq(2'd0, 0, 32'hDEAD, 5'd0, 1, 3'b0, 2'd0);        // edge k+1
    @(posedge clk); #1;                                   // k+2: rd1 write
    n_checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd1, 32'h104})
      $display("FAIL link_wr: got we=%b a=%0d d=%h, required 1 1 00000104",
               rf_we, rf_waddr, rf_wdata); else n_pass++;
    @(posedge clk); #1;                                   // k+3: rd0 retires silently
    n_checks++; if ({rf_we, count} !== {1'b0, 3'd0})
      $display("FAIL rd0_wr: got we=%b cnt=%0d, required 0 0", rf_we, count); else n_pass++;
    enq(2'd2, 0, 32'h2000, 5'd3, 1, 3'b0, 2'd0);        // auipc path
    enq(2'd0, 0, 32'h5555, 5'd6, 0, 3'b0, 2'd0);        // regwrite=0
    enq(2'd3, 0, 32'hABCD_E000, 5'd4, 1, 3'b0, 2'd0);   // lui path
    repeat (5) @(posedge clk); #1;
    n_checks++; if (sb.size() !== 0)
      $display("FAIL link_drain: got %0d pending, required 0", sb.size()); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic bad_cnt = 1'b0;
    for (int i = 0; i < 12; i++) begin
      logic [1:0]  s;
      logic [31:0] v;
      s = (i % 3 == 0) ? 2'd0 : (i % 3 == 1) ? 2'd2 : 2'd3;
      v = 32'h100 + 32'(i) * 32'h11;
      sb.push_back({5'(i + 1), v});
      set_op(s, 1'b1, v, 5'(i + 1), 1, 3'b0, 2'd0);
      @(posedge clk); #1;
      if (count !== 3'd1) bad_cnt = 1'b1;
    end
    in_valid = 1'b0;
    n_checks++; if (bad_cnt !== 1'b0)
      $display("FAIL b2b_count: got unsteady count, required 1 every cycle"); else n_pass++;
    repeat (4) @(posedge clk); #1;
    n_checks++; if ({count, sb.size() == 0} !== {3'd0, 1'b1})
      $display("FAIL b2b_drain: got cnt=%0d pending=%0d, required 0 0", count, sb.size());
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    in_sel = '0; in_jump = 1'b0; in_alu = '0; in_pc_incr = '0; in_pc_offset = '0;
    in_imm = '0; in_rd = '0; in_regwrite = 1'b0; in_funct3 = '0; in_byte_off = '0;
    repeat (2) @(posedge clk); #1;
    test_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    test_reset_midload();
    @(posedge clk); #1;
    test_latency();
    test_load_ext();
    @(posedge clk); #1;
    test_backpressure();
    test_link_rd0();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
